// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between the I-cache and D-cache
// fill FSMs, locking the grant for a whole block fill or one write-through store.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BEATS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] rdata
);

  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL_I,
    FILL_D,
    WRITE_D
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_i_q, last_i_d;
  logic              i_grant_q, d_grant_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pick_i;

  // On a tie, serve whichever side was not served last.
  assign pick_i = i_req & (~d_req | ~last_i_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_i_d = last_i_q;
    unique case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d = FILL_I;
        end else if (d_req) begin
          state_d = d_we ? WRITE_D : FILL_D;
        end
      end
      FILL_I, FILL_D: begin
        if (mem_data_valid) begin
          if (cnt_q == LAST) begin
            state_d  = IDLE;
            cnt_d    = '0;
            last_i_d = (state_q == FILL_I);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE_D: begin
        state_d  = IDLE;
        last_i_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    unique case (state_q)
      FILL_I: begin
        mem_en   = i_req;
        mem_addr = i_addr;
      end
      FILL_D: begin
        mem_en   = d_req;
        mem_addr = d_addr;
      end
      WRITE_D: begin
        mem_en    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: mem_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_i_q  <= 1'b0;
      i_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_i_q  <= last_i_d;
      i_grant_q <= (state_d == FILL_I);
      d_grant_q <= (state_d == FILL_D) || (state_d == WRITE_D);
      wr_q      <= (state_d == WRITE_D);
      addr_q    <= mem_addr;
      wdata_q   <= mem_wdata;
    end
  end

  assign i_grant      = i_grant_q;
  assign d_grant      = d_grant_q;
  assign mem_wr       = wr_q;
  assign i_data_valid = (state_q == FILL_I) & mem_data_valid;
  assign d_data_valid = (state_q == FILL_D) & mem_data_valid;
  assign rdata        = mem_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle table for idle/write/reset behaviour,
// plus fill sequences checked through a beat scoreboard and 4-cycle memory model.
module tb_mem_arbiter;

  localparam logic [15:0] KEY = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_grant, i_data_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_grant, d_data_valid;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_data_in, rdata;
  logic        inj = 1'b0;
  logic [15:0] inj_data = '0;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_grant(i_grant), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_data_valid(d_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .rdata(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: a read accepted at edge N is sampled by the arbiter at edge N+4.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_data_valid = pv[3] | inj;
  assign mem_data_in    = pv[3] ? (pa[3] ^ KEY) : inj_data;

  typedef struct {
    logic        side;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (i_data_valid && d_data_valid) begin
      chk("both_valid", 32'd1, 32'd0);
    end else if (i_data_valid || d_data_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("beat_side", {31'd0, d_data_valid}, {31'd0, e.side});
        chk("beat_data", {16'd0, rdata}, {16'd0, e.data});
      end
    end
  end

  task automatic set_req(input logic side, input logic r,
                         input logic [15:0] a);
    if (side) begin
      d_req  = r;
      d_we   = 1'b0;
      d_addr = a;
    end else begin
      i_req  = r;
      i_addr = a;
    end
  endtask

  task automatic push_beat(input logic side, input logic [15:0] a);
    exp_t e;
    e.side = side;
    e.data = a ^ KEY;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input logic side, output int gcyc);
    gcyc = -1;
    for (int k = 0; k < 100 && gcyc < 0; k++) begin
      @(negedge clk);
      if (side ? d_grant : i_grant) gcyc = cyc;
    end
    if (gcyc < 0) chk(side ? "d_grant_timeout" : "i_grant_timeout", 0, 1);
  endtask

  task automatic do_fill(input logic side, input logic [15:0] base,
                         output int beats, output int gcyc,
                         output int rcyc);
    int issued;
    int lastb;
    logic g, v;
    logic [15:0] a;
    beats = 0;
    rcyc = -1;
    issued = 0;
    lastb = -1;
    set_req(side, 1'b1, base);
    wait_grant(side, gcyc);
    if (gcyc >= 0) begin
      for (int k = 0; k < 100; k++) begin
        g = side ? d_grant : i_grant;
        v = side ? d_data_valid : i_data_valid;
        if (v) begin
          beats++;
          lastb = cyc;
          chk("grant_with_beat", {31'd0, g}, 32'd1);
        end
        if (!g) begin
          rcyc = cyc;
          break;
        end
        if (issued < 8) begin
          a = base + 16'(2 * issued);
          set_req(side, 1'b1, a);
          push_beat(side, a);
          issued++;
        end else begin
          set_req(side, 1'b0, a);
        end
        @(negedge clk);
      end
      chk("fill_beats", beats, 8);
      chk("release_cycle", rcyc, lastb + 1);
    end
    set_req(side, 1'b0, base);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] w,
                          input int delay, output int wc);
    repeat (delay) @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = a;
    d_wdata = w;
    wc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (d_grant) begin
        wc = cyc;
        chk("wr_en", {31'd0, mem_en}, 32'd1);
        chk("wr_strobe", {31'd0, mem_wr}, 32'd1);
        chk("wr_addr", {16'd0, mem_addr}, {16'd0, a});
        chk("wr_data", {16'd0, mem_wdata}, {16'd0, w});
        chk("wr_no_i_grant", {31'd0, i_grant}, 32'd0);
        break;
      end
      chk("wr_waits", {31'd0, mem_wr}, 32'd0);
    end
    if (wc < 0) chk("write_timeout", 0, 1);
    d_req = 1'b0;
    d_we = 1'b0;
    @(negedge clk);
    chk("wr_one_cycle", {31'd0, mem_wr}, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  in;
    logic [15:0] a, w;
    logic [3:0]  out;
    logic [15:0] ea, ew;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    // in = {rst, i_req, d_req, d_we}; out = {i_grant, d_grant, mem_en, mem_wr}
    vec_t tbl [14];
    int b1, g1, r1, b2, g2, r2, wc, c0, gc, issued, beats;
    logic [15:0] a;
    tbl[0]  = '{4'b1000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000};
    tbl[1]  = '{4'b1000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000};
    tbl[2]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000};
    tbl[3]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000};
    tbl[4]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000};
    tbl[5]  = '{4'b0011, 16'h0040, 16'hBEEF, 4'b0111, 16'h0040, 16'hBEEF};
    tbl[6]  = '{4'b0000, 16'h0040, 16'hBEEF, 4'b0000, 16'h0040, 16'hBEEF};
    tbl[7]  = '{4'b0000, 16'h1111, 16'h2222, 4'b0000, 16'h0040, 16'hBEEF};
    tbl[8]  = '{4'b0011, 16'h0002, 16'h0001, 4'b0111, 16'h0002, 16'h0001};
    tbl[9]  = '{4'b0011, 16'h0002, 16'h0001, 4'b0000, 16'h0002, 16'h0001};
    tbl[10] = '{4'b0011, 16'h0003, 16'h0004, 4'b0111, 16'h0003, 16'h0004};
    tbl[11] = '{4'b0000, 16'h0003, 16'h0004, 4'b0000, 16'h0003, 16'h0004};
    tbl[12] = '{4'b1011, 16'h0005, 16'h0006, 4'b0000, 16'h0000, 16'h0000};
    tbl[13] = '{4'b0000, 16'h0005, 16'h0006, 4'b0000, 16'h0000, 16'h0000};

    for (int i = 0; i < 14; i++) begin
      rst     = tbl[i].in[3];
      i_req   = tbl[i].in[2];
      d_req   = tbl[i].in[1];
      d_we    = tbl[i].in[0];
      d_addr  = tbl[i].a;
      d_wdata = tbl[i].w;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t%0d_i_grant", i), {31'd0, i_grant},
          {31'd0, tbl[i].out[3]});
      chk($sformatf("t%0d_d_grant", i), {31'd0, d_grant},
          {31'd0, tbl[i].out[2]});
      chk($sformatf("t%0d_mem_en", i), {31'd0, mem_en},
          {31'd0, tbl[i].out[1]});
      chk($sformatf("t%0d_mem_wr", i), {31'd0, mem_wr},
          {31'd0, tbl[i].out[0]});
      chk($sformatf("t%0d_mem_addr", i), {16'd0, mem_addr},
          {16'd0, tbl[i].ea});
      chk($sformatf("t%0d_mem_wdata", i), {16'd0, mem_wdata},
          {16'd0, tbl[i].ew});
    end

    // Reset leaves last_served = D: plain I fill.
    c0 = cyc;
    do_fill(1'b0, 16'h0010, b1, g1, r1);
    chk("i_grant_latency", g1, c0 + 1);

    // Simultaneous requests after an I fill and a tie policy check.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fork
      do_fill(1'b0, 16'h0200, b1, g1, r1);
      do_fill(1'b1, 16'h0300, b2, g2, r2);
    join
    chk("tie_i_first", {31'd0, g1 < g2}, 32'd1);
    chk("d_after_idle", g2, r1 + 1);

    // Store arriving mid-fill waits for release.
    fork
      do_fill(1'b0, 16'h0020, b1, g1, r1);
      do_write(16'h0040, 16'hBEEF, 3, wc);
    join
    chk("write_after_fill", wc, r1 + 1);

    // Stray valid while idle is dropped and does not advance the count.
    @(negedge clk);
    inj = 1'b1;
    inj_data = 16'h5555;
    @(negedge clk);
    chk("stray_i_valid", {31'd0, i_data_valid}, 32'd0);
    chk("stray_d_valid", {31'd0, d_data_valid}, 32'd0);
    inj = 1'b0;
    do_fill(1'b1, 16'h0400, b2, g2, r2);

    // Reset mid-fill abandons the partial block.
    set_req(1'b1, 1'b1, 16'h0500);
    wait_grant(1'b1, gc);
    issued = 0;
    beats = 0;
    for (int k = 0; k < 100; k++) begin
      if (d_data_valid) beats++;
      if (beats == 3) break;
      if (issued < 8) begin
        a = 16'h0500 + 16'(2 * issued);
        set_req(1'b1, 1'b1, a);
        push_beat(1'b1, a);
        issued++;
      end else begin
        set_req(1'b1, 1'b0, a);
      end
      @(negedge clk);
    end
    chk("pre_rst_beats", beats, 3);
    rst = 1'b1;
    set_req(1'b1, 1'b0, 16'h0500);
    @(negedge clk);
    chk("rst_d_grant", {31'd0, d_grant}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    sb.delete();
    do_fill(1'b1, 16'h0600, b2, g2, r2);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
